// File: rtl/rsa_modexp_ctrl.sv
// rsa_modexp_ctrl
// Constant-time modular exponentiation: result = base^exp mod modulus.
// Right-to-left square-and-multiply, sequencing one shared bit-serial
// interleaved modular multiplier (W cycles per multiply).
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   start    in   request pulse, sampled only while idle
//   base     in   W-bit base (any value, reduced internally)
//   exp      in   W-bit exponent
//   modulus  in   W-bit modulus n
//   busy     out  high from the cycle after start is accepted until the cycle after done
//   done     out  one-cycle pulse, result/err valid from this cycle
//   result   out  W-bit base^exp mod modulus, held until the next done
//   err      out  set with done when modulus < 2
module rsa_modexp_ctrl #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] base,
  input  logic [W-1:0] exp,
  input  logic [W-1:0] modulus,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         err
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REDUCE = 3'd1,
    ST_MUL    = 3'd2,
    ST_SQR    = 3'd3,
    ST_FIN    = 3'd4
  } state_t;

  state_t         state_r;
  logic [W-1:0]   base_r;
  logic [W-1:0]   exp_r;
  logic [W-1:0]   n_r;
  logic [W-1:0]   b_r;
  logic [W-1:0]   r_r;
  logic [W-1:0]   acc_r;
  logic [CW-1:0]  cnt_r;
  logic [CW-1:0]  bit_idx_r;
  logic           busy_r;
  logic           done_r;
  logic [W-1:0]   result_r;
  logic           err_r;

  logic [W-1:0]   a_sel_s;
  logic [W-1:0]   m_sel_s;
  logic [CW-1:0]  m_idx_s;
  logic           m_bit_s;
  logic [W-1:0]   step_s;
  logic           last_s;

  // One cycle of the interleaved multiplier. The intermediate sum needs W+1
  // bits (2*acc or acc+a can reach 2n-2); the return value is always < n.
  function automatic logic [W-1:0] modmul_step(input logic [W-1:0] acc,
                                               input logic [W-1:0] a,
                                               input logic [W-1:0] n,
                                               input logic         mb);
    logic [W:0] t;
    logic [W:0] nn;
    nn = {1'b0, n};
    t  = {acc, 1'b0};
    if (t >= nn) begin
      t = t - nn;
    end else begin
      t = t;
    end
    if (mb) begin
      t = t + {1'b0, a};
      if (t >= nn) begin
        t = t - nn;
      end else begin
        t = t;
      end
    end else begin
      t = t;
    end
    return t[W-1:0];
  endfunction

  // Operand selection for the shared multiplier and its single-step result.
  always_comb begin
    a_sel_s = {W{1'b0}};
    m_sel_s = {W{1'b0}};
    case (state_r)
      ST_REDUCE: begin
        // base mod n computed as 1 * base, so base may exceed n.
        a_sel_s = {{(W-1){1'b0}}, 1'b1};
        m_sel_s = base_r;
      end
      ST_MUL: begin
        a_sel_s = b_r;
        m_sel_s = r_r;
      end
      ST_SQR: begin
        a_sel_s = b_r;
        m_sel_s = b_r;
      end
      default: begin
        a_sel_s = {W{1'b0}};
        m_sel_s = {W{1'b0}};
      end
    endcase
    m_idx_s = CW'(W-1) - cnt_r;
    m_bit_s = m_sel_s[m_idx_s];
    step_s  = modmul_step(acc_r, a_sel_s, n_r, m_bit_s);
    last_s  = (cnt_r == CW'(W-1));
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      base_r    <= {W{1'b0}};
      exp_r     <= {W{1'b0}};
      n_r       <= {W{1'b0}};
      b_r       <= {W{1'b0}};
      r_r       <= {W{1'b0}};
      acc_r     <= {W{1'b0}};
      cnt_r     <= {CW{1'b0}};
      bit_idx_r <= {CW{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      result_r  <= {W{1'b0}};
      err_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            base_r    <= base;
            exp_r     <= exp;
            n_r       <= modulus;
            acc_r     <= {W{1'b0}};
            cnt_r     <= {CW{1'b0}};
            bit_idx_r <= {CW{1'b0}};
            busy_r    <= 1'b1;
            if (modulus < W'(2)) begin
              state_r <= ST_FIN;
            end else begin
              state_r <= ST_REDUCE;
            end
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_REDUCE: begin
          cnt_r <= cnt_r + CW'(1);
          if (last_s) begin
            b_r     <= step_s;
            r_r     <= {{(W-1){1'b0}}, 1'b1};
            acc_r   <= {W{1'b0}};
            state_r <= ST_MUL;
          end else begin
            acc_r <= step_s;
          end
        end
        ST_MUL: begin
          cnt_r <= cnt_r + CW'(1);
          if (last_s) begin
            // Multiply always runs; the product is only kept for set bits.
            if (exp_r[bit_idx_r]) begin
              r_r <= step_s;
            end else begin
              r_r <= r_r;
            end
            acc_r   <= {W{1'b0}};
            state_r <= ST_SQR;
          end else begin
            acc_r <= step_s;
          end
        end
        ST_SQR: begin
          cnt_r <= cnt_r + CW'(1);
          if (last_s) begin
            b_r   <= step_s;
            acc_r <= {W{1'b0}};
            if (bit_idx_r == CW'(W-1)) begin
              // r is final already (SQR never touches it): finish here.
              done_r   <= 1'b1;
              result_r <= r_r;
              err_r    <= 1'b0;
              state_r  <= ST_IDLE;
            end else begin
              bit_idx_r <= bit_idx_r + CW'(1);
              state_r   <= ST_MUL;
            end
          end else begin
            acc_r <= step_s;
          end
        end
        ST_FIN: begin
          // Only reached for modulus < 2.
          done_r   <= 1'b1;
          result_r <= {W{1'b0}};
          err_r    <= 1'b1;
          state_r  <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign result = result_r;
  assign err    = err_r;

endmodule

// File: tb/tb_rsa_modexp_ctrl.sv
module tb_rsa_modexp_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] base;
  logic [W-1:0] exp;
  logic [W-1:0] modulus;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         err;

  int n_checks = 0;
  int n_errors = 0;

  rsa_modexp_ctrl #(.W(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .base    (base),
    .exp     (exp),
    .modulus (modulus),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Reference: plain modular arithmetic, square-and-multiply over exp bits.
  function automatic int ref_modexp(input int b, input int e, input int n);
    int r;
    int bb;
    if (n < 2) return 0;
    r  = 1;
    bb = b % n;
    for (int i = 0; i < W; i++) begin
      if (((e >> i) & 1) == 1) r = (r * bb) % n;
      bb = (bb * bb) % n;
    end
    return r;
  endfunction

  function automatic int ref_latency(input int n);
    return (n < 2) ? 1 : (W + 2 * W * W);
  endfunction

  // Pulse start, then track busy/done until done, check result and timing.
  task automatic run_op(input string tag, input int b, input int e, input int n);
    int  lat;
    bit  busy_ok;
    lat = 0;
    busy_ok = 1'b1;
    @(negedge clk);
    base = W'(b); exp = W'(e); modulus = W'(n); start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(posedge clk);
      #1;
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (done === 1'b1) begin
        lat = cyc;
        break;
      end
    end
    check({tag, "_latency"}, lat, ref_latency(n));
    check({tag, "_busy_held"}, busy_ok, 1);
    check({tag, "_result"}, result, ref_modexp(b, e, n));
    check({tag, "_err"}, err, (n < 2) ? 1 : 0);
    @(posedge clk);
    #1;
    check({tag, "_done_fall"}, done, 0);
    check({tag, "_busy_fall"}, busy, 0);
    check({tag, "_result_hold"}, result, ref_modexp(b, e, n));
  endtask

  initial begin
    int  dones;
    int  lat;
    rst_n = 1'b0; start = 1'b0; base = '0; exp = '0; modulus = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("enc", 2, 7, 33);
    run_op("dec", 29, 3, 33);
    run_op("max", 254, 255, 255);
    run_op("bigbase", 200, 1, 33);
    run_op("exp0", 5, 0, 33);
    run_op("zerobase", 66, 9, 33);
    run_op("mod1", 7, 3, 1);
    run_op("mod0", 7, 3, 0);

    // Start re-pulse and input changes mid-run must be ignored.
    @(negedge clk);
    base = 8'd2; exp = 8'd7; modulus = 8'd33; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    dones = 0;
    lat = 0;
    for (int cyc = 1; cyc <= 160; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc == 30) begin
        base = 8'd9; exp = 8'd5; modulus = 8'd101; start = 1'b1;
      end
      if (cyc == 31) start = 1'b0;
      if (done === 1'b1) begin
        dones++;
        lat = cyc;
      end
    end
    check("midrun_result", result, 29);
    check("midrun_dones", dones, 1);
    check("midrun_latency", lat, 136);

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    base = 8'd2; exp = 8'd7; modulus = 8'd33; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_result", result, 0);
    check("abort_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("after_rst", 3, 5, 7);

    // Randomized operations against the reference model.
    for (int k = 0; k < 12; k++) begin
      int rb, re, rn;
      rb = int'($urandom_range(0, 255));
      re = int'($urandom_range(0, 255));
      rn = (k < 2) ? int'($urandom_range(0, 1)) : int'($urandom_range(2, 255));
      run_op($sformatf("rnd%0d", k), rb, re, rn);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/rsa_modexp_ctrl.md
# rsa_modexp_ctrl

Sequential, constant-time modular-exponentiation engine for the RSA encrypt/decrypt path: computes result = base^exp mod modulus by right-to-left square-and-multiply, sequencing a single shared bit-serial interleaved modular multiplier. It replaces the combinational exponentiation datapath wherever a registered start/busy/done handshake and bounded area are required. It also serves both encryption (exp = e) and decryption (exp = d) from one instance.

## Interface
- W, 8, operand width in bits (base, exp, modulus, result)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request pulse; sampled only in IDLE
- base  input  W  plaintext/ciphertext; any value, need not be < modulus
- exp  input  W  exponent
- modulus  input  W  modulus n
- busy  output  1  high from the cycle after start is accepted until the cycle after done
- done  output  1  one-cycle pulse; result/err valid from this cycle
- result  output  W  base^exp mod modulus; held until the next done
- err  output  1  set with done when modulus < 2; held with result

## Operation
- Reset: busy=0, done=0, result=0, err=0, FSM in IDLE, all internal registers cleared.
- IDLE + start=1: latch base, exp, modulus; if modulus < 2 -> FIN with err=1, result=0; else -> REDUCE with err=0.
- Shared modmul(a, m): interleaved, MSB-first over W bits of m; accumulator acc (W+1 bits), acc=0 initially; per cycle: acc = 2·acc, subtract n if acc >= n; if current bit of m is set, add a, subtract n if acc >= n. Invariant acc < n after every cycle. Exactly W cycles per call. Operand a is always < n.
- REDUCE (W cycles): b = modmul(1, base) = base mod n; r = 1.
- For bit i = 0..W-1 of exp (LSB first):
  - MUL (W cycles): t = modmul(b, r); r = t if exp[i]=1, else r unchanged (multiply always executed; constant time).
  - SQR (W cycles): b = modmul(b, b).
- After bit W-1 SQR -> FIN: result = r (or 0 on err), done=1 for one cycle, then IDLE.
- exp = 0 -> result 1. base ≡ 0 mod n with exp > 0 -> result 0.
- start while busy: ignored, no queuing. Inputs changing while busy: no effect (latched copies used).
- rst_n low mid-operation: immediate abort, all outputs to reset values, no done.

## Timing
- Edge 0 = rising edge sampling start=1 in IDLE.
- Normal path: busy=1 from edge 0; REDUCE edges 0..W-1; MUL/SQR pairs occupy the next 2·W² edges; done rises at edge W + 2·W² (136 for W=8), falls at the next edge together with busy; new start accepted at the edge where busy falls.
- Error path: done (err=1) rises at edge 1, busy falls at edge 2.
- Latency is independent of base and exp values.
- result and err update only at the done-rising edge.

## Test plan
- base=2, exp=7, modulus=33, start pulse -> done exactly 136 cycles after start edge, result=29, err=0; busy high for that whole interval.
- base=29, exp=3, modulus=33 -> result=2 (RSA round trip of the previous case); then base=254, exp=255, modulus=255 -> result=254.
- base=200, exp=1, modulus=33 -> result=2 (base >= n reduced); base=5, exp=0, modulus=33 -> result=1.
- modulus=1 and modulus=0 -> done at edge 1, err=1, result=0; busy low 2 edges after start.
- start re-pulsed and base/exp/modulus changed mid-run of base=2, exp=7, modulus=33 -> ignored, result=29, single done pulse.
- rst_n asserted at cycle 60 of a run -> busy=0, done=0, result=0 immediately; after release, a fresh run of base=3, exp=5, modulus=7 -> result=5.
